// File: rtl/scalar_shift_pipe_fu.sv
// Pipelined scalar shift unit: single-register shifts 110/111 and double-register shifts 112/113.
// Stage 1 computes the result; stages 2..LAT only delay it, and the last stage drives the outputs.
module scalar_shift_pipe_fu #(
   parameter int unsigned W    = 64,
   parameter int unsigned JKW  = 6,
   parameter int unsigned AW   = 32,
   parameter int unsigned LAT  = 3,
   parameter int unsigned TAGW = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_valid,
   input  logic            i_hold,
   input  logic [6:0]      i_Instr,
   input  logic [JKW-1:0]  i_jk,
   input  logic [AW-1:0]   i_Ak,
   input  logic [W-1:0]    i_Si,
   input  logic [W-1:0]    i_Sj,
   input  logic [TAGW-1:0] i_tag,
   output logic            o_valid,
   output logic [W-1:0]    o_Si,
   output logic [TAGW-1:0] o_tag,
   output logic            o_illegal
);

   localparam logic [6:0] OpSll = 7'o110;
   localparam logic [6:0] OpSrl = 7'o111;
   localparam logic [6:0] OpDsl = 7'o112;
   localparam logic [6:0] OpDsr = 7'o113;

   logic [W-1:0]   res_d;
   logic           ill_d;
   logic [JKW-1:0] neg_jk;
   logic [JKW:0]   dcnt;
   logic           ak_big;
   logic [2*W-1:0] dl;
   logic [2*W-1:0] dr;

   always_comb begin
      // W - jk modulo W; jk == 0 means a full-width shift and is handled separately.
      neg_jk = ~i_jk + JKW'(1);
      dcnt   = i_Ak[JKW:0];
      // Any Ak bit at or above 2W pushes everything out of the concatenation.
      ak_big = |i_Ak[AW-1:JKW+1];
      dl     = {i_Si, i_Sj} << dcnt;
      dr     = {i_Sj, i_Si} >> dcnt;
      res_d  = '0;
      ill_d  = 1'b0;
      case (i_Instr)
         OpSll: if (i_jk != '0) res_d = i_Si << neg_jk;
         OpSrl: res_d = i_Si >> i_jk;
         OpDsl: if (!ak_big) res_d = dl[2*W-1:W];
         OpDsr: if (!ak_big) res_d = dr[W-1:0];
         default: ill_d = 1'b1;
      endcase
   end

   logic            valid_q [LAT];
   logic [W-1:0]    res_q   [LAT];
   logic [TAGW-1:0] tag_q   [LAT];
   logic            ill_q   [LAT];

   // Data registers only load behind a valid bit so idle slots keep their last contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < LAT; k++) begin
            valid_q[k] <= 1'b0;
            res_q[k]   <= '0;
            tag_q[k]   <= '0;
            ill_q[k]   <= 1'b0;
         end
      end else if (!i_hold) begin
         valid_q[0] <= i_valid;
         if (i_valid) begin
            res_q[0] <= res_d;
            tag_q[0] <= i_tag;
            ill_q[0] <= ill_d;
         end
         for (int unsigned k = 1; k < LAT; k++) begin
            valid_q[k] <= valid_q[k-1];
            if (valid_q[k-1]) begin
               res_q[k] <= res_q[k-1];
               tag_q[k] <= tag_q[k-1];
               ill_q[k] <= ill_q[k-1];
            end
         end
      end
   end

   assign o_valid   = valid_q[LAT-1];
   assign o_Si      = res_q[LAT-1];
   assign o_tag     = tag_q[LAT-1];
   assign o_illegal = ill_q[LAT-1];

endmodule

// File: tb/tb_scalar_shift_pipe_fu.sv
// Scoreboard bench for scalar_shift_pipe_fu: a W=64/LAT=3 instance and a W=32/LAT=1 instance.
module tb_scalar_shift_pipe_fu;

   typedef struct {
      logic [63:0] res;
      logic [2:0]  tag;
      logic        ill;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: wide arithmetic shifts, masked to width w.
   function automatic logic [63:0] model(input int w, input logic [6:0] op, input logic [5:0] jk,
                                         input logic [31:0] ak, input logic [63:0] si,
                                         input logic [63:0] sj, output logic ill);
      logic [63:0]  mask;
      logic [127:0] cat;
      logic [127:0] tmp;
      logic [63:0]  r;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      ill  = 1'b0;
      r    = '0;
      case (op)
         7'o110: r = (si << (w - int'(jk))) & mask;
         7'o111: r = si >> jk;
         7'o112: begin
            cat = ({64'b0, si} << w) | {64'b0, sj};
            tmp = (cat << ak) >> w;
            r   = tmp[63:0] & mask;
         end
         7'o113: begin
            cat = ({64'b0, sj} << w) | {64'b0, si};
            tmp = cat >> ak;
            r   = tmp[63:0] & mask;
         end
         default: ill = 1'b1;
      endcase
      return r;
   endfunction

   // ---------------- Instance A: W=64, LAT=3 ----------------
   logic        rst_a = 1'b1, hold_a = 1'b0, va = 1'b0;
   logic [6:0]  op_a = '0;
   logic [5:0]  jk_a = '0;
   logic [31:0] ak_a = '0;
   logic [63:0] si_a = '0, sj_a = '0;
   logic [2:0]  tg_a = '0;
   logic        ov_a, oill_a;
   logic [63:0] osi_a;
   logic [2:0]  otg_a;

   scalar_shift_pipe_fu #(.W(64), .JKW(6), .AW(32), .LAT(3), .TAGW(3)) u_dut_a (
      .clk       (clk),
      .rst       (rst_a),
      .i_valid   (va),
      .i_hold    (hold_a),
      .i_Instr   (op_a),
      .i_jk      (jk_a),
      .i_Ak      (ak_a),
      .i_Si      (si_a),
      .i_Sj      (sj_a),
      .i_tag     (tg_a),
      .o_valid   (ov_a),
      .o_Si      (osi_a),
      .o_tag     (otg_a),
      .o_illegal (oill_a)
   );

   // ---------------- Instance B: W=32, LAT=1 ----------------
   logic        rst_b = 1'b1, hold_b = 1'b0, vb = 1'b0;
   logic [6:0]  op_b = '0;
   logic [4:0]  jk_b = '0;
   logic [31:0] ak_b = '0;
   logic [31:0] si_b = '0, sj_b = '0;
   logic [2:0]  tg_b = '0;
   logic        ov_b, oill_b;
   logic [31:0] osi_b;
   logic [2:0]  otg_b;

   scalar_shift_pipe_fu #(.W(32), .JKW(5), .AW(32), .LAT(1), .TAGW(3)) u_dut_b (
      .clk       (clk),
      .rst       (rst_b),
      .i_valid   (vb),
      .i_hold    (hold_b),
      .i_Instr   (op_b),
      .i_jk      (jk_b),
      .i_Ak      (ak_b),
      .i_Si      (si_b),
      .i_Sj      (sj_b),
      .i_tag     (tg_b),
      .o_valid   (ov_b),
      .o_Si      (osi_b),
      .o_tag     (otg_b),
      .o_illegal (oill_b)
   );

   exp_t q_a[$], q_b[$];
   int   edge_a = 0, edge_b = 0;
   exp_t last_a, last_b;
   logic last_vld_a = 1'b0, last_vld_b = 1'b0;

   // Edges that advance the pipeline are counted; an entry is due on exactly one of them.
   always @(posedge clk) begin
      exp_t e;
      logic h, r;
      h = hold_a;
      r = rst_a;
      if (r || !h) edge_a++;
      #1;
      if (r) begin
         q_a.delete();
         last_vld_a = 1'b0;
         check_eq("a_rst_valid", 64'(ov_a), 64'd0);
         check_eq("a_rst_si", osi_a, 64'd0);
         check_eq("a_rst_tag", 64'(otg_a), 64'd0);
         check_eq("a_rst_ill", 64'(oill_a), 64'd0);
      end else if (!h) begin
         if (q_a.size() > 0 && q_a[0].due == edge_a) begin
            e = q_a.pop_front();
            check_eq("a_valid", 64'(ov_a), 64'd1);
            check_eq("a_si", osi_a, e.res);
            check_eq("a_tag", 64'(otg_a), 64'(e.tag));
            check_eq("a_ill", 64'(oill_a), 64'(e.ill));
            last_a     = e;
            last_vld_a = 1'b1;
         end else begin
            check_eq("a_idle_valid", 64'(ov_a), 64'd0);
            last_vld_a = 1'b0;
         end
      end else begin
         check_eq("a_hold_valid", 64'(ov_a), 64'(last_vld_a));
         if (last_vld_a) begin
            check_eq("a_hold_si", osi_a, last_a.res);
            check_eq("a_hold_tag", 64'(otg_a), 64'(last_a.tag));
         end
      end
   end

   always @(posedge clk) begin
      exp_t e;
      logic h, r;
      h = hold_b;
      r = rst_b;
      if (r || !h) edge_b++;
      #1;
      if (r) begin
         q_b.delete();
         last_vld_b = 1'b0;
         check_eq("b_rst_valid", 64'(ov_b), 64'd0);
         check_eq("b_rst_si", 64'(osi_b), 64'd0);
      end else if (!h) begin
         if (q_b.size() > 0 && q_b[0].due == edge_b) begin
            e = q_b.pop_front();
            check_eq("b_valid", 64'(ov_b), 64'd1);
            check_eq("b_si", 64'(osi_b), e.res);
            check_eq("b_tag", 64'(otg_b), 64'(e.tag));
            check_eq("b_ill", 64'(oill_b), 64'(e.ill));
            last_b     = e;
            last_vld_b = 1'b1;
         end else begin
            check_eq("b_idle_valid", 64'(ov_b), 64'd0);
            last_vld_b = 1'b0;
         end
      end
   end

   task automatic issue_a(input logic [6:0] op, input logic [5:0] jk, input logic [31:0] ak,
                          input logic [63:0] si, input logic [63:0] sj, input logic [2:0] tag);
      exp_t e;
      logic il;
      @(negedge clk);
      va = 1'b1; op_a = op; jk_a = jk; ak_a = ak; si_a = si; sj_a = sj; tg_a = tag;
      e.res = model(64, op, jk, ak, si, sj, il);
      e.ill = il;
      e.tag = tag;
      e.due = edge_a + 3;
      q_a.push_back(e);
   endtask

   task automatic idle_a(input int n);
      repeat (n) begin
         @(negedge clk);
         va = 1'b0;
      end
   endtask

   task automatic hold_a_for(input int n);
      @(negedge clk);
      va     = 1'b0;
      hold_a = 1'b1;
      repeat (n - 1) @(negedge clk);
      @(negedge clk);
      hold_a = 1'b0;
   endtask

   task automatic issue_b(input logic [6:0] op, input logic [4:0] jk, input logic [31:0] ak,
                          input logic [31:0] si, input logic [31:0] sj, input logic [2:0] tag);
      exp_t e;
      logic il;
      @(negedge clk);
      vb = 1'b1; op_b = op; jk_b = jk; ak_b = ak; si_b = si; sj_b = sj; tg_b = tag;
      e.res = model(32, op, {1'b0, jk}, ak, {32'b0, si}, {32'b0, sj}, il);
      e.ill = il;
      e.tag = tag;
      e.due = edge_b + 1;
      q_b.push_back(e);
   endtask

   localparam logic [63:0] DSj = 64'hFFFF_0000_0000_0000;

   initial begin
      repeat (3) @(negedge clk);
      rst_a = 1'b0;
      rst_b = 1'b0;

      issue_a(7'o111, 6'd4, 32'd0, 64'h8000_0000_0000_00F0, 64'd0, 3'd5);
      idle_a(5);
      issue_a(7'o110, 6'd0, 32'd0, '1, 64'd0, 3'd1);
      issue_a(7'o110, 6'd63, 32'd0, 64'd1, 64'd0, 3'd2);
      issue_a(7'o112, 6'd0, 32'd16, 64'd1, DSj, 3'd3);
      issue_a(7'o112, 6'd0, 32'd64, 64'd1, DSj, 3'd4);
      issue_a(7'o112, 6'd0, 32'd128, 64'd1, DSj, 3'd5);
      issue_a(7'o112, 6'd0, 32'h8000_0000, 64'd1, DSj, 3'd6);
      issue_a(7'o112, 6'd0, 32'd0, 64'h1234, DSj, 3'd7);
      issue_a(7'o113, 6'd0, 32'd1, 64'd1, DSj, 3'd0);
      issue_a(7'o113, 6'd0, 32'd64, 64'd1, DSj, 3'd1);
      issue_a(7'o113, 6'd0, 32'd0, 64'h55AA, DSj, 3'd2);
      issue_a(7'o113, 6'd0, 32'd200, 64'd1, DSj, 3'd3);
      issue_a(7'o111, 6'd0, 32'd0, 64'hDEAD_BEEF_0000_0001, 64'd0, 3'd4);
      issue_a(7'o114, 6'd5, 32'd9, 64'hFFFF, 64'd1, 3'd2);
      idle_a(5);

      // Back-to-back burst, then a burst interrupted by a two-clock hold.
      for (int i = 0; i < 4; i++)
         issue_a(7'o111, 6'(i), 32'd0, 64'hF0F0_F0F0_F0F0_F0F0, 64'd0, 3'(i));
      idle_a(5);
      for (int i = 0; i < 4; i++)
         issue_a(7'o112, 6'd0, 32'(i * 7), 64'h0123_4567_89AB_CDEF, DSj, 3'(i + 4));
      hold_a_for(2);
      for (int i = 0; i < 3; i++)
         issue_a(7'o113, 6'd0, 32'(i * 9 + 3), 64'h0123_4567_89AB_CDEF, DSj, 3'(i));
      idle_a(6);

      // Reset while two ops are in flight: neither may emerge.
      issue_a(7'o111, 6'd1, 32'd0, 64'hFF, 64'd0, 3'd6);
      issue_a(7'o111, 6'd2, 32'd0, 64'hFF, 64'd0, 3'd7);
      @(negedge clk);
      va    = 1'b0;
      rst_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;
      idle_a(6);

      for (int i = 0; i < 20; i++)
         issue_a(7'(7'o110 + $urandom_range(0, 4)), 6'($urandom), 32'($urandom_range(0, 140)),
                 {$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom));
      idle_a(6);

      issue_b(7'o111, 5'd4, 32'd0, 32'h8000_00F0, 32'd0, 3'd5);
      issue_b(7'o110, 5'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 3'd1);
      issue_b(7'o110, 5'd31, 32'd0, 32'd1, 32'd0, 3'd2);
      issue_b(7'o112, 5'd0, 32'd16, 32'd1, 32'hFFFF_0000, 3'd3);
      issue_b(7'o112, 5'd0, 32'd32, 32'd1, 32'hFFFF_0000, 3'd4);
      issue_b(7'o112, 5'd0, 32'd64, 32'd1, 32'hFFFF_0000, 3'd5);
      issue_b(7'o112, 5'd0, 32'h8000_0000, 32'd1, 32'hFFFF_0000, 3'd6);
      issue_b(7'o113, 5'd0, 32'd1, 32'd1, 32'hFFFF_0000, 3'd7);
      issue_b(7'o113, 5'd0, 32'd32, 32'd1, 32'hFFFF_0000, 3'd0);
      issue_b(7'o114, 5'd0, 32'd0, 32'd7, 32'd7, 3'd2);
      @(negedge clk);
      vb = 1'b0;
      repeat (4) @(negedge clk);

      check_eq("a_drain", 64'(q_a.size()), 64'd0);
      check_eq("b_drain", 64'(q_b.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
